// File: rtl/vit_tb_ctrl.sv
// Sequencing controller for the (3,2,2) Viterbi decoder: ACS timing, survivor
// memory write addressing, traceback address generation and output strobe.
module vit_tb_ctrl #(
    parameter int TB_DEPTH   = 10,
    parameter int PTR_W      = 4,
    parameter int ACS_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seq_ready,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             acs_en,
    output logic             we,
    output logic [PTR_W-1:0] write_ptr,
    output logic             te,
    output logic             tb_load,
    output logic [PTR_W-1:0] trace_ptr,
    output logic             oe,
    output logic             busy,
    output logic             overrun
);

    // state   | meaning
    // S_IDLE  | waiting for a symbol strobe
    // S_ACS   | ACS units running, ACS_CYCLES cycles
    // S_WRITE | survivor column written at write_ptr
    // S_TRACE | traceback over TB_DEPTH columns, newest to oldest
    // S_OUT   | decoded output valid
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACS,
        S_WRITE,
        S_TRACE,
        S_OUT
    } state_t;

    localparam int ACS_W = (ACS_CYCLES > 1) ? $clog2(ACS_CYCLES) : 1;
    localparam logic [ACS_W-1:0] ACS_LOAD  = ACS_W'(ACS_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(TB_DEPTH - 1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(TB_DEPTH);

    state_t           state;
    state_t           next_state;
    logic [ACS_W-1:0] acs_cnt;
    logic [PTR_W-1:0] trace_cnt;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   fill_inc;
    logic [PTR_W-1:0] wp_inc;
    logic [PTR_W-1:0] tp_dec;
    logic             accept;

    assign accept   = (state == S_IDLE) && sym_valid && seq_ready;
    assign fill_inc = (fill >= FILL_FULL) ? FILL_FULL : fill + 1'b1;
    assign wp_inc   = (write_ptr == PTR_LAST) ? '0 : write_ptr + 1'b1;
    assign tp_dec   = (trace_ptr == '0) ? PTR_LAST : trace_ptr - 1'b1;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_ACS;
            S_ACS:   if (acs_cnt == '0) next_state = S_WRITE;
            S_WRITE: next_state = (fill_inc == FILL_FULL) ? S_TRACE : S_IDLE;
            S_TRACE: if (trace_cnt == '0) next_state = S_OUT;
            S_OUT:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign sym_ready = (state == S_IDLE) && seq_ready;
    assign acs_en    = (state == S_ACS);
    assign we        = (state == S_WRITE);
    assign te        = (state == S_TRACE);
    assign tb_load   = (state == S_TRACE) && (trace_cnt == PTR_LAST);
    assign oe        = (state == S_OUT);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            acs_cnt   <= '0;
            trace_cnt <= '0;
            fill      <= '0;
            write_ptr <= '0;
            trace_ptr <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= next_state;
            if (sym_valid && seq_ready && (state != S_IDLE))
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (accept) acs_cnt <= ACS_LOAD;
                S_ACS:  if (acs_cnt != '0) acs_cnt <= acs_cnt - 1'b1;
                S_WRITE: begin
                    write_ptr <= wp_inc;
                    fill      <= fill_inc;
                    // traceback starts at the column written this cycle
                    if (fill_inc == FILL_FULL) begin
                        trace_ptr <= write_ptr;
                        trace_cnt <= PTR_LAST;
                    end
                end
                S_TRACE: begin
                    if (trace_cnt != '0) begin
                        trace_cnt <= trace_cnt - 1'b1;
                        trace_ptr <= tp_dec;
                    end
                end
                default: ;
            endcase
            // end of stream: restart filling from an empty memory
            if ((next_state == S_IDLE) && !seq_ready) begin
                fill      <= '0;
                write_ptr <= '0;
            end
        end
    end

endmodule

// File: doc/vit_tb_ctrl.md
Name: vit_tb_ctrl

Overview:
Sequencing controller for the (3,2,2) backward-label Viterbi decoder datapath. It accepts received symbols and runs the ACS update phase. It writes each survivor column into the circular survivor memory and runs a full traceback of TB_DEPTH steps once the memory is full. It then strobes the decoded output. It produces the we/te/oe enables and the write_ptr/trace_ptr addresses that the ACS, survivor-memory and traceback units consume.

Parameters:
TB_DEPTH, 10, survivor memory depth and traceback length in symbols; must satisfy 2 <= TB_DEPTH <= 2**PTR_W.
PTR_W, 4, width of write_ptr and trace_ptr.
ACS_CYCLES, 3, clock cycles the ACS units need per symbol; must be >= 1.

Ports:
clock  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
seq_ready  in  1  stream active; low ends the sequence and clears fill/pointers once idle
sym_valid  in  1  single-cycle strobe: new Rx symbol present this cycle
sym_ready  out  1  controller can accept a symbol (IDLE and seq_ready)
acs_en  out  1  ACS/path-metric units enabled
we  out  1  write survivor column at write_ptr
write_ptr  out  PTR_W  survivor memory write address
te  out  1  traceback enable
tb_load  out  1  traceback unit loads min_state into tb_reg (first trace cycle)
trace_ptr  out  PTR_W  survivor memory read address for traceback
oe  out  1  decoded k-bit output (Dx) valid this cycle
busy  out  1  controller not in IDLE
overrun  out  1  sticky: a symbol strobe was dropped

Behaviour:
- Clock is clock. Reset is synchronous, active-high, on port reset. Asserting reset in any state forces IDLE on the next edge.
- Reset values: all outputs 0 except sym_ready, which follows seq_ready combinationally once in IDLE. Internal fill count = 0, ACS counter = 0, trace counter = 0.
- FSM states: IDLE, ACS, WRITE, TRACE, OUT.
- IDLE:
  - sym_ready = seq_ready.
  - Accept when sym_valid & seq_ready.
  - If the accept is at edge t: ACS occupies cycles t+1 .. t+ACS_CYCLES, with acs_en = 1.
- WRITE: one cycle, at t+ACS_CYCLES+1.
  - we = 1 at the current write_ptr.
  - On exit: write_ptr increments, wrapping TB_DEPTH-1 -> 0.
  - On exit: fill = min(fill+1, TB_DEPTH).
  - If the updated fill == TB_DEPTH, go to TRACE; otherwise go to IDLE.
- TRACE: exactly TB_DEPTH cycles with te = 1.
  - Cycle 0: tb_load = 1, and trace_ptr = the address just written (write_ptr-1, modulo TB_DEPTH).
  - Each following cycle: trace_ptr decrements, wrapping 0 -> TB_DEPTH-1.
  - The last trace cycle addresses the oldest column, which equals the new write_ptr.
- OUT: one cycle with oe = 1; trace_ptr holds the oldest address. Then go to IDLE.
- Symbol period:
  - Before fill reaches TB_DEPTH: 1 + ACS_CYCLES + 1 cycles (IDLE, ACS, WRITE) = 5 with defaults.
  - Steady state: 1 + ACS_CYCLES + 1 + TB_DEPTH + 1 cycles = 16 with defaults.
- busy = 1 in every state except IDLE. acs_en, we, te, tb_load and oe are mutually exclusive and are all 0 in IDLE.
- overrun:
  - Set when sym_valid = 1 in any state other than IDLE while seq_ready = 1. That symbol is dropped.
  - Cleared only by reset.
  - sym_valid while seq_ready = 0 is ignored silently.
- seq_ready dropping mid-operation: the current symbol completes all its phases, including TRACE/OUT if already due. On reaching IDLE with seq_ready = 0, fill and write_ptr clear to 0 on that edge.
- seq_ready low in IDLE: fill and write_ptr are held at 0 and no symbol is accepted.
- Simultaneous return to IDLE and sym_valid: the symbol is accepted only when the current state is IDLE. A strobe on the OUT cycle sets overrun.
- fill saturates at TB_DEPTH and never wraps. write_ptr never exceeds TB_DEPTH-1.

Test Plan:
- Reset, then hold reset 3 cycles while driving sym_valid -> all outputs 0, overrun = 0, write_ptr = 0, no we/acs_en pulses.
- seq_ready = 1, 9 symbols each 5 cycles apart -> per symbol: 3 acs_en cycles then one we pulse, write_ptr 0..8, with te and oe never asserted.
- 10th symbol -> we at write_ptr = 9, then 10 te cycles. tb_load is on the first te cycle only. trace_ptr runs 9,8,...,0. oe pulses once, and write_ptr = 0 afterwards.
- 11th symbol, strobed 16 cycles after the 10th -> we at write_ptr = 0, trace_ptr runs 0,9,8,...,1, then oe, then write_ptr = 1.
- Strobe sym_valid during TRACE -> overrun = 1 and stays 1. No extra we or ACS cycle occurs, and pointer sequences are unchanged.
- seq_ready = 0 mid-TRACE -> trace and oe complete, then IDLE with write_ptr = 0 and fill = 0. A subsequent sequence needs 10 symbols before the first te.
- Reset asserted mid-ACS or mid-TRACE -> IDLE next edge, all enables 0, pointers 0, overrun cleared.
